pc_gen: RTL and testbench

Parametrised program-counter generator for the IF stage. It replaces the two-way next-PC mux with a registered PC that selects among several redirect sources by priority. It also holds redirects that arrive while instruction memory is backpressuring, and drives a valid/ready fetch request toward instruction memory. The IF stage uses its kill output to discard wrong-path fetches.

---
 rtl/pc_gen.sv | 98 +++++++++
 tb/tb_pc_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// IF-stage program counter with prioritised redirects and a one-entry redirect buffer.
// Latency: redirect applied on the accepting edge; buffered redirects on the next accept.
// Backpressure: fetch_addr_o holds while fetch_ready_i=0; a redirect arriving then is buffered.
module pc_gen #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                INC      = 4,
  parameter logic [ADDR_W-1:0] TRAP_VEC = 32'h0000_1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_ready_i,
  input  logic              trap_i,
  input  logic              eret_i,
  input  logic [ADDR_W-1:0] epc_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_target_i,
  output logic              fetch_req_o,
  output logic [ADDR_W-1:0] fetch_addr_o,
  output logic              fetch_kill_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc4_o,
  output logic              redirect_pending_o,
  output logic              misalign_o
);

  logic [ADDR_W-1:0] pc;
  logic              fetch_req;
  logic              pend_vld;
  logic [ADDR_W-1:0] pend_tgt;
  logic              misalign;

  logic              accept;
  logic              exc_redirect;
  logic              redirect_now;
  logic              take_new;
  logic [ADDR_W-1:0] sel_raw;
  logic [ADDR_W-1:0] sel_tgt;

  // Priority select of the redirect target; exception redirects always win,
  // EX redirects are wrong-path once a redirect is already buffered.
  always_comb begin
    sel_raw = '0;
    if (trap_i)        sel_raw = TRAP_VEC;
    else if (eret_i)   sel_raw = epc_i;
    else if (branch_i) sel_raw = branch_target_i;
    else if (jump_i)   sel_raw = jump_target_i;
    exc_redirect = trap_i | eret_i;
    redirect_now = exc_redirect | branch_i | jump_i;
    take_new     = exc_redirect | (~pend_vld & redirect_now);
    sel_tgt      = {sel_raw[ADDR_W-1:2], 2'b00};
    accept       = fetch_req & fetch_ready_i;
  end

  // PC, request, pending buffer and misalignment flag update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      fetch_req <= 1'b0;
      pend_vld  <= 1'b0;
      pend_tgt  <= '0;
      misalign  <= 1'b0;
    end else begin
      fetch_req <= 1'b1;
      misalign  <= take_new & (sel_raw[1:0] != 2'b00);
      if (accept) begin
        if (exc_redirect) begin
          pc       <= sel_tgt;
          pend_vld <= 1'b0;
        end else if (pend_vld) begin
          pc       <= pend_tgt;
          pend_vld <= 1'b0;
        end else if (redirect_now) begin
          pc <= sel_tgt;
        end else begin
          pc <= pc4_o;
        end
      end else if (take_new) begin
        pend_tgt <= sel_tgt;
        pend_vld <= 1'b1;
      end
    end
  end

  // Output drive; the kill marks the beat at the old PC as wrong-path.
  always_comb begin
    pc_o               = pc;
    fetch_addr_o       = pc;
    pc4_o              = pc + ADDR_W'(INC);
    fetch_req_o        = fetch_req;
    fetch_kill_o       = accept & (pend_vld | redirect_now);
    redirect_pending_o = pend_vld;
    misalign_o         = misalign;
  end

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios with literal expectations, then random traffic
// compared every cycle against a queue-based reference model.
module tb_pc_gen;

  localparam logic [31:0] TV = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ready = 1'b1;
  logic        trap = 1'b0, eret = 1'b0, branch = 1'b0, jump = 1'b0;
  logic [31:0] epc = '0, btgt = '0, jtgt = '0;
  logic        req, kill, pend, mis;
  logic [31:0] addr, pc, pc4;

  int errors = 0;
  int checks = 0;

  pc_gen dut (
    .clk(clk), .rst_n(rst_n), .fetch_ready_i(ready),
    .trap_i(trap), .eret_i(eret), .epc_i(epc),
    .branch_i(branch), .branch_target_i(btgt),
    .jump_i(jump), .jump_target_i(jtgt),
    .fetch_req_o(req), .fetch_addr_o(addr), .fetch_kill_o(kill),
    .pc_o(pc), .pc4_o(pc4), .redirect_pending_o(pend), .misalign_o(mis)
  );

  always #5 clk = ~clk;

  // Reference model: PC value, request flag, buffered redirect as a queue of at most one.
  logic        m_req;
  logic [31:0] m_pc;
  logic [31:0] m_pq[$];
  logic        m_mis;

  function automatic logic [31:0] pick_target();
    if (trap)   return TV;
    if (eret)   return epc;
    if (branch) return btgt;
    return jtgt;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_req = 1'b0;
      m_pc  = 32'h0;
      m_pq.delete();
      m_mis = 1'b0;
    end else begin
      logic        any, exc, use_new, acc;
      logic [31:0] t;
      acc     = m_req && ready;
      exc     = trap || eret;
      any     = exc || branch || jump;
      use_new = exc || (m_pq.size() == 0 && any);
      t       = pick_target();
      m_mis   = use_new && (t % 4 != 0);
      t       = t - (t % 4);
      if (acc) begin
        if (exc) begin
          m_pc = t;
          m_pq.delete();
        end else if (m_pq.size() != 0) begin
          m_pc = m_pq.pop_front();
        end else if (any) begin
          m_pc = t;
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end else if (use_new) begin
        m_pq.delete();
        m_pq.push_back(t);
      end
      m_req = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic exp_kill;
    exp_kill = m_req && ready && (m_pq.size() != 0 || trap || eret || branch || jump);
    chk("m_req",  {31'b0, req},  {31'b0, m_req});
    chk("m_pc",   pc,            m_pc);
    chk("m_addr", addr,          m_pc);
    chk("m_pc4",  pc4,           m_pc + 32'd4);
    chk("m_pend", {31'b0, pend}, {31'b0, (m_pq.size() != 0)});
    chk("m_mis",  {31'b0, mis},  {31'b0, m_mis});
    chk("m_kill", {31'b0, kill}, {31'b0, exp_kill});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    trap = 0; eret = 0; branch = 0; jump = 0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'b0, req}, 32'h0);
    chk("rst_pend", {31'b0, pend}, 32'h0);
    chk("rst_mis", {31'b0, mis}, 32'h0);
    step();
    rst_n = 1;
    step();
    chk("seq0", addr, 32'h0);
    chk("req_up", {31'b0, req}, 32'h1);
    step(); chk("seq4", addr, 32'h4);
    step(); chk("seq8", addr, 32'h8);
    // Backpressure holds the address
    ready = 0;
    for (int i = 0; i < 3; i++) begin
      step(); chk("hold8", addr, 32'h8);
    end
    ready = 1;
    step(); chk("seqC", addr, 32'hC);
    step(); chk("seq10", addr, 32'h10);
    // Taken branch with ready
    branch = 1; btgt = 32'h40; #1;
    chk("br_kill", {31'b0, kill}, 32'h1);
    step(); clr();
    chk("br_pc", pc, 32'h40);
    step(); chk("br_pc4", pc, 32'h44);
    // Get to 0x20, then buffer a branch and ignore a later jump
    jump = 1; jtgt = 32'h20; step(); clr();
    chk("j20", pc, 32'h20);
    ready = 0; branch = 1; btgt = 32'h80; step(); clr();
    chk("pend_set", {31'b0, pend}, 32'h1);
    chk("pend_pc", pc, 32'h20);
    jump = 1; jtgt = 32'h90; step(); clr();
    chk("pend_keep", {31'b0, pend}, 32'h1);
    ready = 1; #1;
    chk("pend_kill", {31'b0, kill}, 32'h1);
    step();
    chk("pend_apply", pc, 32'h80);
    chk("pend_clr", {31'b0, pend}, 32'h0);
    // Trap beats branch, with and without a buffered redirect
    trap = 1; branch = 1; btgt = 32'h200; step(); clr();
    chk("trap_pc", pc, 32'h1000);
    ready = 0; branch = 1; btgt = 32'h80; step(); clr();
    ready = 1; trap = 1; branch = 1; step(); clr();
    chk("trap_pend_pc", pc, 32'h1000);
    chk("trap_pend_clr", {31'b0, pend}, 32'h0);
    // Misaligned jump target
    jump = 1; jtgt = 32'h103; step(); clr();
    chk("mis_pc", pc, 32'h100);
    chk("mis_on", {31'b0, mis}, 32'h1);
    step(); chk("mis_off", {31'b0, mis}, 32'h0);
    // Wrap
    jump = 1; jtgt = 32'hFFFF_FFFC; step(); clr();
    chk("top_pc", pc, 32'hFFFF_FFFC);
    step(); chk("wrap_pc", pc, 32'h0);
    // Reset while a redirect is buffered
    ready = 0; branch = 1; btgt = 32'h300; step(); clr();
    chk("pre_rst_pend", {31'b0, pend}, 32'h1);
    rst_n = 0; #1;
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_pend", {31'b0, pend}, 32'h0);
    step();
    rst_n = 1; ready = 1;

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      ready  = ($urandom_range(0, 3) != 0);
      trap   = ($urandom_range(0, 19) == 0);
      eret   = ($urandom_range(0, 11) == 0);
      branch = ($urandom_range(0, 5) == 0);
      jump   = ($urandom_range(0, 7) == 0);
      epc    = $urandom();
      btgt   = $urandom();
      jtgt   = $urandom();
      if ($urandom_range(0, 1) == 0) begin
        epc[1:0] = 2'b00; btgt[1:0] = 2'b00; jtgt[1:0] = 2'b00;
      end
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 0;
        step();
        rst_n = 1;
      end else begin
        step();
      end
    end
    clr();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
